// File: rtl/npu_mem_master_if.sv
// Bundle of command, write-stream, read-stream, status and memory-port signals
// for npu_mem_master. The master modport is the burst engine's view. The slave
// modport is the view from the surrounding control, stream and memory logic.
interface npu_mem_master_if #(
   parameter int AXI_WIDTH = 32,
   parameter int ADDR_W    = 6,
   parameter int LEN_W     = 7
);
   // command channel
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [LEN_W-1:0]     cmd_len;
   // write-data stream
   logic                 wr_valid;
   logic                 wr_ready;
   logic [AXI_WIDTH-1:0] wr_data;
   // read-data stream
   logic                 rd_valid;
   logic                 rd_ready;
   logic [AXI_WIDTH-1:0] rd_data;
   // status
   logic                 busy;
   logic                 done;
   // SRAM-like word port
   logic                 req_o;
   logic [3:0]           wen_o;
   logic [ADDR_W-1:0]    addr_o;
   logic [AXI_WIDTH-1:0] wdata_o;
   logic [AXI_WIDTH-1:0] rdata_i;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, rdata_i,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, req_o, wen_o, addr_o, wdata_o
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, rdata_i,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, req_o, wen_o, addr_o, wdata_o
   );
endinterface

// File: rtl/npu_mem_master.sv
// Burst engine for the NPU word port. It splits one command into single-word
// accesses. Write bursts take their data from a valid/ready stream. Read bursts
// return data through a 2-entry FIFO. Read issue is credit-limited, so a
// returned word always has room in the FIFO.
module npu_mem_master #(
   parameter int AXI_WIDTH = 32,
   parameter int ADDR_W    = 6,
   parameter int LEN_W     = 7
) (
   input  logic             clk,
   input  logic             reset,
   npu_mem_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

   state_t               state, state_nxt;
   logic [ADDR_W-1:0]    cur_addr;
   logic [LEN_W-1:0]     remaining;

   logic                 req_q;
   logic [3:0]           wen_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [AXI_WIDTH-1:0] wdata_q;

   logic [AXI_WIDTH-1:0] fifo_mem [0:1];
   logic                 fifo_rd_ptr, fifo_wr_ptr;
   logic [1:0]           fifo_cnt, fifo_cnt_nxt;
   logic                 inflight;

   logic                 cmd_ready_c, wr_ready_c, busy_c, done_c;
   logic                 cmd_fire, wr_fire, rd_issue, rd_push, rd_pop, rd_valid_c;
   logic [2:0]           rd_fill, rd_limit;

   assign rd_valid_c = (fifo_cnt != 2'd0);
   assign cmd_fire   = cmd_ready_c && bus.cmd_valid;
   assign wr_fire    = wr_ready_c && bus.wr_valid;
   assign rd_pop     = rd_valid_c && bus.rd_ready;
   // The word read in the cycle req_o is high is captured at the end of that cycle.
   assign rd_push    = inflight;
   assign fifo_cnt_nxt = fifo_cnt + {1'b0, rd_push} - {1'b0, rd_pop};
   // A read may be issued only if every word already in the FIFO or in flight
   // still fits after the pop. The pop frees one slot this cycle, which keeps a
   // word per cycle moving while the consumer stays ready.
   assign rd_fill    = {1'b0, fifo_cnt} + {2'b00, inflight};
   assign rd_limit   = 3'd2 + {2'b00, rd_pop};

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-state handshake and status outputs.
   always_comb begin
      // NOTE: each output gets a default before the case statement, so no path can infer a latch.
      state_nxt   = state;
      cmd_ready_c = 1'b0;
      wr_ready_c  = 1'b0;
      busy_c      = 1'b1;
      done_c      = 1'b0;
      rd_issue    = 1'b0;
      unique case (state)
         IDLE: begin
            busy_c      = 1'b0;
            cmd_ready_c = 1'b1;
            // A zero-length burst spends one empty cycle in its burst state.
            // This places done two cycles after the command is accepted.
            if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ;
         end
         WRITE: begin
            // After the last beat is accepted, one more cycle lets the final
            // write reach the bus before done is raised.
            wr_ready_c = (remaining != '0);
            if (remaining == '0) state_nxt = FINISH;
         end
         READ: begin
            rd_issue = (remaining != '0) && (rd_fill < rd_limit);
            if ((remaining == '0) && !inflight && (fifo_cnt_nxt == 2'd0)) state_nxt = FINISH;
         end
         FINISH: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Burst counters and the registered memory-port outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_addr  <= '0;
         remaining <= '0;
         req_q     <= 1'b0;
         wen_q     <= 4'h0;
         addr_q    <= '0;
         wdata_q   <= '0;
         inflight  <= 1'b0;
      end else begin
         req_q    <= 1'b0;
         wen_q    <= 4'h0;
         inflight <= rd_issue;
         if (cmd_fire) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_len;
         end else if (wr_fire || rd_issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
         end
         if (wr_fire) begin
            req_q   <= 1'b1;
            wen_q   <= 4'hF;
            addr_q  <= cur_addr;
            wdata_q <= bus.wr_data;
         end else if (rd_issue) begin
            req_q  <= 1'b1;
            addr_q <= cur_addr;
         end
      end
   end

   // Read FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fifo_rd_ptr <= 1'b0;
         fifo_wr_ptr <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         if (rd_push) fifo_wr_ptr <= ~fifo_wr_ptr;
         if (rd_pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
         fifo_cnt <= fifo_cnt_nxt;
      end
   end

   // Read FIFO storage, written with the returned memory word.
   always_ff @(posedge clk) begin
      // NOTE: storage needs no reset, because the cleared occupancy already masks stale entries.
      if (rd_push) fifo_mem[fifo_wr_ptr] <= bus.rdata_i;
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.wr_ready  = wr_ready_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.rd_valid  = rd_valid_c;
   assign bus.rd_data   = fifo_mem[fifo_rd_ptr];
   assign bus.req_o     = req_q;
   assign bus.wen_o     = wen_q;
   assign bus.addr_o    = addr_q;
   assign bus.wdata_o   = wdata_q;

endmodule
